// File: rtl/affine_pkg.sv
// Shared types and constants for the affine transform sequencer and its ALU.
// Operand-select codes are plain constants so the decoder ports stay simple vectors.
package affine_pkg;

    typedef enum logic [1:0] {
        RB  = 2'b00,
        ADD = 2'b01,
        MUL = 2'b10
    } alu_func_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int N_STEPS   = 8;
    localparam int FRAC_BITS = 7;
    localparam int STEP_W    = $clog2(N_STEPS);

    localparam logic [2:0] SA_ZERO = 3'd0;
    localparam logic [2:0] SA_A11  = 3'd1;
    localparam logic [2:0] SA_A12  = 3'd2;
    localparam logic [2:0] SA_A21  = 3'd3;
    localparam logic [2:0] SA_A22  = 3'd4;
    localparam logic [2:0] SA_ACC  = 3'd5;

    localparam logic [2:0] SB_ZERO = 3'd0;
    localparam logic [2:0] SB_X1   = 3'd1;
    localparam logic [2:0] SB_Y1   = 3'd2;
    localparam logic [2:0] SB_TMP  = 3'd3;
    localparam logic [2:0] SB_B1   = 3'd4;
    localparam logic [2:0] SB_B2   = 3'd5;

endpackage

// File: rtl/affine_step_dec.sv
// Step decoder: maps the step index to ALU operand selects, function and the
// register that captures the ALU result. Inactive means the ALU idles at RB/0/0.
module affine_step_dec
    import affine_pkg::*;
(
    input  logic              active_i,
    input  logic [STEP_W-1:0] step_i,
    output logic [2:0]        sel_a_o,
    output logic [2:0]        sel_b_o,
    output logic [1:0]        func_o,
    output logic              en_acc_o,
    output logic              en_tmp_o,
    output logic              en_x2_o,
    output logic              en_y2_o
);

    alu_func_t func;

    assign func_o = func;

    always_comb begin
        sel_a_o  = SA_ZERO;
        sel_b_o  = SB_ZERO;
        func     = RB;
        en_acc_o = 1'b0;
        en_tmp_o = 1'b0;
        en_x2_o  = 1'b0;
        en_y2_o  = 1'b0;
        if (active_i) begin
            case (step_i)
                3'd0: begin sel_a_o = SA_A11; sel_b_o = SB_X1;  func = MUL; en_acc_o = 1'b1; end
                3'd1: begin sel_a_o = SA_A12; sel_b_o = SB_Y1;  func = MUL; en_tmp_o = 1'b1; end
                3'd2: begin sel_a_o = SA_ACC; sel_b_o = SB_TMP; func = ADD; en_acc_o = 1'b1; end
                3'd3: begin sel_a_o = SA_ACC; sel_b_o = SB_B1;  func = ADD; en_x2_o  = 1'b1; end
                3'd4: begin sel_a_o = SA_A21; sel_b_o = SB_X1;  func = MUL; en_acc_o = 1'b1; end
                3'd5: begin sel_a_o = SA_A22; sel_b_o = SB_Y1;  func = MUL; en_tmp_o = 1'b1; end
                3'd6: begin sel_a_o = SA_ACC; sel_b_o = SB_TMP; func = ADD; en_acc_o = 1'b1; end
                3'd7: begin sel_a_o = SA_ACC; sel_b_o = SB_B2;  func = ADD; en_y2_o  = 1'b1; end
            endcase
        end
    end

endmodule

// File: rtl/affine_seq.sv
// Affine transform sequencer: drives a shared external ALU through eight steps
// per job, with valid/ready handshakes on the job and result sides.
module affine_seq
    import affine_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         nReset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] y1,
    input  logic [W-1:0] a11,
    input  logic [W-1:0] a12,
    input  logic [W-1:0] a21,
    input  logic [W-1:0] a22,
    input  logic [W-1:0] b1,
    input  logic [W-1:0] b2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] x2,
    output logic [W-1:0] y2,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [1:0]   alu_func,
    input  logic [W-1:0] alu_result
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [W-1:0]      acc_q, tmp_q, x2_q, y2_q;
    logic [W-1:0]      x1_q, y1_q, a11_q, a12_q, a21_q, a22_q, b1_q, b2_q;
    logic [2:0]        sel_a, sel_b;
    logic              en_acc, en_tmp, en_x2, en_y2;
    logic              accept, active;

    assign accept = (state_q == S_IDLE) && in_valid;
    assign active = (state_q == S_RUN);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            S_IDLE: if (in_valid) begin
                state_d = S_RUN;
                step_d  = '0;
            end
            S_RUN: begin
                if (step_q == LAST_STEP) begin
                    state_d = S_DONE;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    affine_step_dec u_dec (
        .active_i (active),
        .step_i   (step_q),
        .sel_a_o  (sel_a),
        .sel_b_o  (sel_b),
        .func_o   (alu_func),
        .en_acc_o (en_acc),
        .en_tmp_o (en_tmp),
        .en_x2_o  (en_x2),
        .en_y2_o  (en_y2)
    );

    always_comb begin
        alu_a = '0;
        alu_b = '0;
        case (sel_a)
            SA_A11:  alu_a = a11_q;
            SA_A12:  alu_a = a12_q;
            SA_A21:  alu_a = a21_q;
            SA_A22:  alu_a = a22_q;
            SA_ACC:  alu_a = acc_q;
            default: alu_a = '0;
        endcase
        case (sel_b)
            SB_X1:   alu_b = x1_q;
            SB_Y1:   alu_b = y1_q;
            SB_TMP:  alu_b = tmp_q;
            SB_B1:   alu_b = b1_q;
            SB_B2:   alu_b = b2_q;
            default: alu_b = '0;
        endcase
    end

    // Every register clears on reset so an aborted job leaves nothing behind.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            acc_q   <= '0;
            tmp_q   <= '0;
            x2_q    <= '0;
            y2_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            a11_q   <= '0;
            a12_q   <= '0;
            a21_q   <= '0;
            a22_q   <= '0;
            b1_q    <= '0;
            b2_q    <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            if (accept) begin
                x1_q  <= x1;
                y1_q  <= y1;
                a11_q <= a11;
                a12_q <= a12;
                a21_q <= a21;
                a22_q <= a22;
                b1_q  <= b1;
                b2_q  <= b2;
            end
            if (en_acc) acc_q <= alu_result;
            if (en_tmp) tmp_q <= alu_result;
            if (en_x2)  x2_q  <= alu_result;
            if (en_y2)  y2_q  <= alu_result;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign x2        = x2_q;
    assign y2        = y2_q;

endmodule

// File: tb/tb_affine_seq.sv
// Bench for affine_seq: supplies the ALU, keeps a job-level model of the
// handshakes and results, and runs directed jobs with hand-computed answers.
module tb_affine_seq;
    import affine_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              nReset, in_valid, in_ready, out_valid, out_ready;
    logic signed [7:0] x1, y1, a11, a12, a21, a22, b1, b2;
    logic signed [7:0] x2, y2, alu_a, alu_b, alu_result;
    logic [1:0]        alu_func;
    logic signed [15:0] prod;

    affine_seq #(.W(8)) dut (
        .clk(clk), .nReset(nReset), .in_valid(in_valid), .in_ready(in_ready),
        .x1(x1), .y1(y1), .a11(a11), .a12(a12), .a21(a21), .a22(a22),
        .b1(b1), .b2(b2), .out_valid(out_valid), .out_ready(out_ready),
        .x2(x2), .y2(y2), .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
        .alu_result(alu_result)
    );

    // The ALU the parent would instantiate.
    assign prod = alu_a * alu_b;
    always_comb begin
        alu_result = '0;
        case (alu_func)
            2'b00:   alu_result = alu_b;
            2'b01:   alu_result = alu_a + alu_b;
            2'b10:   alu_result = 8'(prod >>> FRAC_BITS);
            default: alu_result = '0;
        endcase
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic signed [7:0] mulq(input logic signed [7:0] a, input logic signed [7:0] b);
        int p;
        p = (int'(a) * int'(b)) >>> FRAC_BITS;
        return 8'(p);
    endfunction

    // Job-level model: 0 idle, 1 running (m_k = step shown), 2 result held.
    int                m_state, m_k;
    logic signed [7:0] ea[8], eb[8];
    logic [1:0]        ef[8];
    logic signed [7:0] ex2, ey2;

    always @(posedge clk or negedge nReset) begin
        logic signed [7:0] p0, p1, s0, q0, q1, s1;
        if (!nReset) begin
            m_state = 0;
            m_k     = 0;
        end else begin
            case (m_state)
                0: if (in_valid) begin
                    p0 = mulq(a11, x1);  p1 = mulq(a12, y1);  s0 = p0 + p1;
                    q0 = mulq(a21, x1);  q1 = mulq(a22, y1);  s1 = q0 + q1;
                    ex2 = s0 + b1;
                    ey2 = s1 + b2;
                    ea = '{a11, a12, p0, s0, a21, a22, q0, s1};
                    eb = '{x1, y1, p1, b1, x1, y1, q1, b2};
                    ef = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
                    m_state = 1;
                    m_k     = 0;
                end
                1: if (m_k == 7) m_state = 2; else m_k++;
                default: if (out_ready) m_state = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (nReset === 1'b1) begin
            check("in_ready", 8'(in_ready), 8'(m_state == 0));
            check("out_valid", 8'(out_valid), 8'(m_state == 2));
            check("func_not_11", 8'(alu_func == 2'b11), 8'd0);
            if (m_state == 1) begin
                check("alu_func_step", 8'(alu_func), 8'(ef[m_k]));
                check("alu_a_step", alu_a, ea[m_k]);
                check("alu_b_step", alu_b, eb[m_k]);
                if (m_k >= 4) check("x2_hold_run", x2, ex2);
            end else begin
                check("alu_a_idle", alu_a, 8'd0);
                check("alu_b_idle", alu_b, 8'd0);
                check("alu_func_idle", 8'(alu_func), 8'd0);
            end
            if (m_state == 2) begin
                check("x2_model", x2, ex2);
                check("y2_model", y2, ey2);
            end
        end
    end

    logic [1:0] trace[8];
    int         lat;

    task automatic start_job(input logic [7:0] vx1, vy1, va11, va12, va21, va22, vb1, vb2);
        x1 = vx1;  y1 = vy1;  a11 = va11;  a12 = va12;
        a21 = va21;  a22 = va22;  b1 = vb1;  b2 = vb2;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x1 = 8'($urandom);  y1 = 8'($urandom);  a11 = 8'($urandom);  a12 = 8'($urandom);
        a21 = 8'($urandom); a22 = 8'($urandom); b1 = 8'($urandom);   b2 = 8'($urandom);
    endtask

    task automatic wait_out(output int l);
        l = 0;
        trace[0] = alu_func;
        while (!out_valid && l < 20) begin
            @(posedge clk); #1;
            l++;
            if (l < 8) trace[l] = alu_func;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("in_ready_after_take", 8'(in_ready), 8'd1);
        check("out_valid_after_take", 8'(out_valid), 8'd0);
    endtask

    task automatic run_job(input logic [7:0] vx1, vy1, va11, va12, va21, va22, vb1, vb2,
                           input logic [7:0] exp_x2, exp_y2, input string tag);
        start_job(vx1, vy1, va11, va12, va21, va22, vb1, vb2);
        wait_out(lat);
        check({tag, "_latency"}, 8'(lat), 8'd8);
        check({tag, "_x2"}, x2, exp_x2);
        check({tag, "_y2"}, y2, exp_y2);
        release_out();
    endtask

    initial begin
        logic [1:0]        exp_tr[8];
        logic signed [7:0] rx, ry, r11, r12, r21, r22, rb1, rb2, ox, oy;
        nReset = 1'b0;  in_valid = 1'b0;  out_ready = 1'b0;
        x1 = '0; y1 = '0; a11 = '0; a12 = '0; a21 = '0; a22 = '0; b1 = '0; b2 = '0;
        #2;
        check("rst_in_ready", 8'(in_ready), 8'd1);
        check("rst_out_valid", 8'(out_valid), 8'd0);
        check("rst_x2", x2, 8'd0);
        check("rst_y2", y2, 8'd0);
        check("rst_alu_func", 8'(alu_func), 8'd0);
        repeat (2) @(posedge clk);
        #1 nReset = 1'b1;
        @(posedge clk); #1;

        // Basic job plus the ALU function trace across the eight steps.
        run_job(8'd10, 8'd20, 8'h40, 8'h40, 8'hC0, 8'h40, 8'd3, 8'hFC, 8'd18, 8'd1, "basic");
        exp_tr = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
        for (int i = 0; i < 8; i++) check("func_trace", 8'(trace[i]), 8'(exp_tr[i]));

        run_job(8'hFB, 8'd0, 8'h40, 8'h00, 8'h60, 8'h00, 8'd0, 8'd0, 8'hFD, 8'hFC, "floor");
        run_job(8'd100, 8'd100, 8'h40, 8'h40, 8'h00, 8'h00, 8'd100, 8'd7, 8'hC8, 8'd7, "wrap");

        // Backpressure: result held while a new offer waits.
        start_job(8'd10, 8'd20, 8'h40, 8'h40, 8'hC0, 8'h40, 8'd3, 8'hFC);
        wait_out(lat);
        check("bp_latency", 8'(lat), 8'd8);
        x1 = 8'hFB; y1 = 8'd0; a11 = 8'h40; a12 = 8'h00; a21 = 8'h60; a22 = 8'h00; b1 = 8'd0; b2 = 8'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_x2", x2, 8'd18);
            check("bp_y2", y2, 8'd1);
            check("bp_in_ready", 8'(in_ready), 8'd0);
            check("bp_out_valid", 8'(out_valid), 8'd1);
        end
        release_out();
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp2_accepted", 8'(in_ready), 8'd0);
        wait_out(lat);
        check("bp2_latency", 8'(lat), 8'd8);
        check("bp2_x2", x2, 8'hFD);
        check("bp2_y2", y2, 8'hFC);
        release_out();

        // Reset during step 4 of the wrap job.
        start_job(8'd100, 8'd100, 8'h40, 8'h40, 8'h00, 8'h00, 8'd100, 8'd7);
        repeat (4) begin @(posedge clk); #1; end
        #2 nReset = 1'b0;
        #1;
        check("mid_rst_out_valid", 8'(out_valid), 8'd0);
        check("mid_rst_in_ready", 8'(in_ready), 8'd1);
        check("mid_rst_x2", x2, 8'd0);
        check("mid_rst_y2", y2, 8'd0);
        @(posedge clk); #1 nReset = 1'b1;
        repeat (3) begin @(posedge clk); #1; check("aborted_no_out", 8'(out_valid), 8'd0); end
        run_job(8'd10, 8'd20, 8'h40, 8'h40, 8'hC0, 8'h40, 8'd3, 8'hFC, 8'd18, 8'd1, "post_rst");

        // A few pseudo-random jobs with answers from plain arithmetic.
        for (int j = 0; j < 4; j++) begin
            rx = 8'($urandom);  ry = 8'($urandom);  r11 = 8'($urandom); r12 = 8'($urandom);
            r21 = 8'($urandom); r22 = 8'($urandom); rb1 = 8'($urandom); rb2 = 8'($urandom);
            ox = mulq(r11, rx) + mulq(r12, ry) + rb1;
            oy = mulq(r21, rx) + mulq(r22, ry) + rb2;
            run_job(rx, ry, r11, r12, r21, r22, rb1, rb2, ox, oy, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
